// File: rtl/multicycle_ctrl.sv
// Control FSM for the multi-cycle MIPS-subset datapath: shared memory port with
// ready handshake and timeout, illegal-opcode trap and retired-instruction count.
module multicycle_ctrl #(
  parameter int unsigned TO_W    = 8,
  parameter int unsigned TIMEOUT = 200,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic [5:0]       instr_op_i,
  input  logic [5:0]       funct_i,
  input  logic             mem_ready_i,
  output logic             PCWrite_o,
  output logic             PCWriteCond_o,
  output logic             BranchType_o,
  output logic             IorD_o,
  output logic             MemRead_o,
  output logic             MemWrite_o,
  output logic             IRWrite_o,
  output logic [1:0]       RegDst_o,
  output logic [1:0]       MemtoReg_o,
  output logic             RegWrite_o,
  output logic             ALUSrcA_o,
  output logic [1:0]       ALUSrcB_o,
  output logic [2:0]       ALUOp_o,
  output logic [1:0]       PCSource_o,
  output logic             err_o,
  output logic [3:0]       state_o,
  output logic [CNT_W-1:0] instr_cnt_o
);

  typedef enum logic [3:0] {
    S_START  = 4'd0,  S_FETCH  = 4'd1,  S_DECODE = 4'd2,  S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,  S_MEMWB  = 4'd5,  S_MEMWR  = 4'd6,  S_EXEC   = 4'd7,
    S_RWB    = 4'd8,  S_BRANCH = 4'd9,  S_JUMP   = 4'd10, S_JAL    = 4'd11,
    S_JR     = 4'd12, S_ADDIEX = 4'd13, S_ADDIWB = 4'd14, S_ERR    = 4'd15
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] FN_JR   = 6'b001000;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_type;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
    logic       err;
  } ctl_t;

  state_t          state, nxt;
  ctl_t            ctl_q;
  logic            fetch_q;
  logic [TO_W-1:0] to_cnt, to_nxt;
  logic            retire;
  logic            waiting;

  function automatic ctl_t decode(input state_t s, input logic [5:0] op);
    ctl_t c;
    c = '0;
    case (s)
      S_FETCH:  c.mem_read = 1'b1;
      S_DECODE: c.alu_src_b = 2'd3;
      S_MEMADR, S_ADDIEX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'd2;
      end
      S_MEMRD: begin
        c.iord     = 1'b1;
        c.mem_read = 1'b1;
      end
      S_MEMWB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 2'd1;
      end
      S_MEMWR: begin
        c.iord      = 1'b1;
        c.mem_write = 1'b1;
      end
      S_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 3'd2;
      end
      S_RWB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 2'd1;
      end
      S_ADDIWB: c.reg_write = 1'b1;
      S_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_op        = 3'd1;
        c.pc_write_cond = 1'b1;
        c.pc_source     = 2'd1;
        c.branch_type   = op[0];
      end
      S_JUMP: begin
        c.pc_write  = 1'b1;
        c.pc_source = 2'd2;
      end
      S_JAL: begin
        c.pc_write   = 1'b1;
        c.pc_source  = 2'd2;
        c.reg_write  = 1'b1;
        c.reg_dst    = 2'd2;
        c.mem_to_reg = 2'd2;
      end
      S_JR: begin
        c.pc_write  = 1'b1;
        c.pc_source = 2'd3;
      end
      S_ERR:   c.err = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

  always_comb begin
    nxt     = state;
    to_nxt  = '0;
    retire  = 1'b0;
    waiting = 1'b0;
    case (state)
      S_START: nxt = S_FETCH;
      S_FETCH: begin
        if (mem_ready_i) nxt = S_DECODE;
        else             waiting = 1'b1;
      end
      S_DECODE: begin
        case (instr_op_i)
          OP_LW, OP_SW:   nxt = S_MEMADR;
          OP_R:           nxt = (funct_i == FN_JR) ? S_JR : S_EXEC;
          OP_ADDI:        nxt = S_ADDIEX;
          OP_BEQ, OP_BNE: nxt = S_BRANCH;
          OP_J:           nxt = S_JUMP;
          OP_JAL:         nxt = S_JAL;
          default:        nxt = S_ERR;
        endcase
      end
      S_MEMADR: nxt = (instr_op_i == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD: begin
        if (mem_ready_i) nxt = S_MEMWB;
        else             waiting = 1'b1;
      end
      S_MEMWR: begin
        if (mem_ready_i) begin
          nxt    = S_FETCH;
          retire = 1'b1;
        end else begin
          waiting = 1'b1;
        end
      end
      S_EXEC:   nxt = S_RWB;
      S_ADDIEX: nxt = S_ADDIWB;
      S_MEMWB, S_RWB, S_ADDIWB, S_BRANCH, S_JUMP, S_JAL, S_JR: begin
        nxt    = S_FETCH;
        retire = 1'b1;
      end
      S_ERR:   nxt = S_ERR;
      default: nxt = S_ERR;
    endcase
    // Ready on the final allowed cycle takes the normal path above, so trap only while waiting.
    if (waiting) begin
      if (to_cnt == TO_W'(TIMEOUT - 1)) nxt = S_ERR;
      else                              to_nxt = to_cnt + TO_W'(1);
    end
  end

  // Moore outputs are registered from the next state; fetch_q enables the ready-gated FETCH terms.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_START;
      ctl_q       <= '0;
      fetch_q     <= 1'b0;
      to_cnt      <= '0;
      instr_cnt_o <= '0;
    end else begin
      state   <= nxt;
      ctl_q   <= decode(nxt, instr_op_i);
      fetch_q <= (nxt == S_FETCH);
      to_cnt  <= to_nxt;
      if (retire) instr_cnt_o <= instr_cnt_o + CNT_W'(1);
    end
  end

  logic fetch_done;
  assign fetch_done = fetch_q & mem_ready_i;

  assign PCWrite_o     = ctl_q.pc_write | fetch_done;
  assign PCWriteCond_o = ctl_q.pc_write_cond;
  assign BranchType_o  = ctl_q.branch_type;
  assign IorD_o        = ctl_q.iord;
  assign MemRead_o     = ctl_q.mem_read;
  assign MemWrite_o    = ctl_q.mem_write;
  assign IRWrite_o     = fetch_done;
  assign RegDst_o      = ctl_q.reg_dst;
  assign MemtoReg_o    = ctl_q.mem_to_reg;
  assign RegWrite_o    = ctl_q.reg_write;
  assign ALUSrcA_o     = ctl_q.alu_src_a;
  assign ALUSrcB_o     = fetch_done ? 2'd1 : ctl_q.alu_src_b;
  assign ALUOp_o       = ctl_q.alu_op;
  assign PCSource_o    = ctl_q.pc_source;
  assign err_o         = ctl_q.err;
  assign state_o       = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle state and control-vector checks
// for each instruction class, wait states, timeout, illegal opcode and counter wrap.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [5:0] instr_op = '0;
  logic [5:0] funct = '0;
  logic       mem_ready = 1'b1;
  logic       pc_write, pc_write_cond, branch_type, iord, mem_read, mem_write, ir_write;
  logic [1:0] reg_dst, mem_to_reg, alu_src_b, pc_source;
  logic       reg_write, alu_src_a, err;
  logic [2:0] alu_op;
  logic [3:0] state;
  logic [3:0] instr_cnt;

  int errors = 0;
  int checks = 0;
  logic [3:0] exp_cnt = '0;

  multicycle_ctrl #(.TO_W(8), .TIMEOUT(5), .CNT_W(4)) dut (
    .clk_i(clk), .rst_n(rst_n), .instr_op_i(instr_op), .funct_i(funct),
    .mem_ready_i(mem_ready), .PCWrite_o(pc_write), .PCWriteCond_o(pc_write_cond),
    .BranchType_o(branch_type), .IorD_o(iord), .MemRead_o(mem_read),
    .MemWrite_o(mem_write), .IRWrite_o(ir_write), .RegDst_o(reg_dst),
    .MemtoReg_o(mem_to_reg), .RegWrite_o(reg_write), .ALUSrcA_o(alu_src_a),
    .ALUSrcB_o(alu_src_b), .ALUOp_o(alu_op), .PCSource_o(pc_source),
    .err_o(err), .state_o(state), .instr_cnt_o(instr_cnt)
  );

  always #5 clk = ~clk;

  // {pcw,pcwc,bt,iord,mrd,mwr,irw} regdst memtoreg rw srca srcb aluop pcsrc err
  logic [20:0] outs;
  assign outs = {pc_write, pc_write_cond, branch_type, iord, mem_read, mem_write, ir_write,
                 reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, err};

  localparam logic [20:0] E_ZERO     = '0;
  localparam logic [20:0] E_FETCH_NR = {7'b0000100, 14'd0};
  localparam logic [20:0] E_FETCH_R  = {7'b1000101, 2'd0, 2'd0, 1'b0, 1'b0, 2'd1, 3'd0, 2'd0, 1'b0};
  localparam logic [20:0] E_DECODE   = {7'b0000000, 2'd0, 2'd0, 1'b0, 1'b0, 2'd3, 3'd0, 2'd0, 1'b0};
  localparam logic [20:0] E_MEMADR   = {7'b0000000, 2'd0, 2'd0, 1'b0, 1'b1, 2'd2, 3'd0, 2'd0, 1'b0};
  localparam logic [20:0] E_MEMRD    = {7'b0001100, 14'd0};
  localparam logic [20:0] E_MEMWB    = {7'b0000000, 2'd0, 2'd1, 1'b1, 1'b0, 2'd0, 3'd0, 2'd0, 1'b0};
  localparam logic [20:0] E_MEMWR    = {7'b0001010, 14'd0};
  localparam logic [20:0] E_EXEC     = {7'b0000000, 2'd0, 2'd0, 1'b0, 1'b1, 2'd0, 3'd2, 2'd0, 1'b0};
  localparam logic [20:0] E_RWB      = {7'b0000000, 2'd1, 2'd0, 1'b1, 1'b0, 2'd0, 3'd0, 2'd0, 1'b0};
  localparam logic [20:0] E_ADDIEX   = E_MEMADR;
  localparam logic [20:0] E_ADDIWB   = {7'b0000000, 2'd0, 2'd0, 1'b1, 1'b0, 2'd0, 3'd0, 2'd0, 1'b0};
  localparam logic [20:0] E_BNE      = {7'b0110000, 2'd0, 2'd0, 1'b0, 1'b1, 2'd0, 3'd1, 2'd1, 1'b0};
  localparam logic [20:0] E_BEQ      = {7'b0100000, 2'd0, 2'd0, 1'b0, 1'b1, 2'd0, 3'd1, 2'd1, 1'b0};
  localparam logic [20:0] E_JUMP     = {7'b1000000, 2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 3'd0, 2'd2, 1'b0};
  localparam logic [20:0] E_JAL      = {7'b1000000, 2'd2, 2'd2, 1'b1, 1'b0, 2'd0, 3'd0, 2'd2, 1'b0};
  localparam logic [20:0] E_JR       = {7'b1000000, 2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 3'd0, 2'd3, 1'b0};
  localparam logic [20:0] E_ERR      = 21'd1;

  localparam logic [5:0] OP_R = 6'b000000, OP_ADDI = 6'b001000, OP_LW = 6'b100011,
                         OP_SW = 6'b101011, OP_BEQ = 6'b000100, OP_BNE = 6'b000101,
                         OP_J = 6'b000010, OP_JAL = 6'b000011, OP_BAD = 6'b111111;
  localparam logic [5:0] FN_ADD = 6'b100000, FN_JR = 6'b001000;

  typedef struct {
    logic        rdy;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [3:0]  st;
    logic [20:0] out;
  } step_t;

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    checks++;
    if (state !== 4'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
    checks++;
    if (outs !== E_ZERO) begin errors++; $display("FAIL reset_outs: got %h expected %h", outs, E_ZERO); end
    checks++;
    if (instr_cnt !== 4'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", instr_cnt); end
    @(posedge clk);
    #3 rst_n = 1'b1;
    #1;
    checks++;
    if (state !== 4'd0) begin errors++; $display("FAIL reset_release_state: got %0d expected 0", state); end
    mem_ready = 1'b1;
    tick();
    #1;
    checks++;
    if (state !== 4'd1 || outs !== E_FETCH_R) begin
      errors++; $display("FAIL reset_to_fetch: got state %0d outs %h expected 1 %h", state, outs, E_FETCH_R);
    end
  endtask

  task automatic test_add;
    step_t seq[$];
    seq.push_back('{1'b1, OP_R, FN_ADD, 4'd1, E_FETCH_R});
    seq.push_back('{1'b1, OP_R, FN_ADD, 4'd2, E_DECODE});
    seq.push_back('{1'b1, OP_R, FN_ADD, 4'd7, E_EXEC});
    seq.push_back('{1'b1, OP_R, FN_ADD, 4'd8, E_RWB});
    seq.push_back('{1'b1, OP_R, FN_ADD, 4'd1, E_FETCH_R});
    for (int i = 0; i < seq.size(); i++) begin
      mem_ready = seq[i].rdy; instr_op = seq[i].op; funct = seq[i].fn;
      #1;
      checks++;
      if (state !== seq[i].st) begin errors++; $display("FAIL add_state[%0d]: got %0d expected %0d", i, state, seq[i].st); end
      checks++;
      if (outs !== seq[i].out) begin errors++; $display("FAIL add_ctl[%0d]: got %h expected %h", i, outs, seq[i].out); end
      if (i < seq.size() - 1) tick();
    end
    exp_cnt = exp_cnt + 4'd1;
    checks++;
    if (instr_cnt !== exp_cnt) begin errors++; $display("FAIL add_cnt: got %0d expected %0d", instr_cnt, exp_cnt); end
  endtask

  task automatic test_lw_wait;
    step_t seq[$];
    seq.push_back('{1'b1, OP_LW, 6'd0, 4'd1, E_FETCH_R});
    seq.push_back('{1'b1, OP_LW, 6'd0, 4'd2, E_DECODE});
    seq.push_back('{1'b1, OP_LW, 6'd0, 4'd3, E_MEMADR});
    seq.push_back('{1'b0, OP_LW, 6'd0, 4'd4, E_MEMRD});
    seq.push_back('{1'b0, OP_LW, 6'd0, 4'd4, E_MEMRD});
    seq.push_back('{1'b0, OP_LW, 6'd0, 4'd4, E_MEMRD});
    seq.push_back('{1'b1, OP_LW, 6'd0, 4'd4, E_MEMRD});
    seq.push_back('{1'b1, OP_LW, 6'd0, 4'd5, E_MEMWB});
    seq.push_back('{1'b1, OP_LW, 6'd0, 4'd1, E_FETCH_R});
    for (int i = 0; i < seq.size(); i++) begin
      mem_ready = seq[i].rdy; instr_op = seq[i].op; funct = seq[i].fn;
      #1;
      checks++;
      if (state !== seq[i].st) begin errors++; $display("FAIL lw_state[%0d]: got %0d expected %0d", i, state, seq[i].st); end
      checks++;
      if (outs !== seq[i].out) begin errors++; $display("FAIL lw_ctl[%0d]: got %h expected %h", i, outs, seq[i].out); end
      if (i < seq.size() - 1) tick();
    end
    exp_cnt = exp_cnt + 4'd1;
    checks++;
    if (instr_cnt !== exp_cnt) begin errors++; $display("FAIL lw_cnt: got %0d expected %0d", instr_cnt, exp_cnt); end
  endtask

  task automatic test_branch_jal;
    step_t seq[$];
    seq.push_back('{1'b1, OP_BNE, 6'd0, 4'd1,  E_FETCH_R});
    seq.push_back('{1'b1, OP_BNE, 6'd0, 4'd2,  E_DECODE});
    seq.push_back('{1'b1, OP_BNE, 6'd0, 4'd9,  E_BNE});
    seq.push_back('{1'b1, OP_JAL, 6'd0, 4'd1,  E_FETCH_R});
    seq.push_back('{1'b1, OP_JAL, 6'd0, 4'd2,  E_DECODE});
    seq.push_back('{1'b1, OP_JAL, 6'd0, 4'd11, E_JAL});
    seq.push_back('{1'b1, OP_JAL, 6'd0, 4'd1,  E_FETCH_R});
    for (int i = 0; i < seq.size(); i++) begin
      mem_ready = seq[i].rdy; instr_op = seq[i].op; funct = seq[i].fn;
      #1;
      checks++;
      if (state !== seq[i].st) begin errors++; $display("FAIL br_state[%0d]: got %0d expected %0d", i, state, seq[i].st); end
      checks++;
      if (outs !== seq[i].out) begin errors++; $display("FAIL br_ctl[%0d]: got %h expected %h", i, outs, seq[i].out); end
      if (i < seq.size() - 1) tick();
    end
    exp_cnt = exp_cnt + 4'd2;
    checks++;
    if (instr_cnt !== exp_cnt) begin errors++; $display("FAIL br_cnt: got %0d expected %0d", instr_cnt, exp_cnt); end
  endtask

  task automatic test_back_to_back;
    step_t seq[$];
    seq.push_back('{1'b1, OP_SW,   6'd0,  4'd1,  E_FETCH_R});
    seq.push_back('{1'b1, OP_SW,   6'd0,  4'd2,  E_DECODE});
    seq.push_back('{1'b1, OP_SW,   6'd0,  4'd3,  E_MEMADR});
    seq.push_back('{1'b1, OP_SW,   6'd0,  4'd6,  E_MEMWR});
    seq.push_back('{1'b1, OP_ADDI, 6'd0,  4'd1,  E_FETCH_R});
    seq.push_back('{1'b1, OP_ADDI, 6'd0,  4'd2,  E_DECODE});
    seq.push_back('{1'b1, OP_ADDI, 6'd0,  4'd13, E_ADDIEX});
    seq.push_back('{1'b1, OP_ADDI, 6'd0,  4'd14, E_ADDIWB});
    seq.push_back('{1'b1, OP_BEQ,  6'd0,  4'd1,  E_FETCH_R});
    seq.push_back('{1'b1, OP_BEQ,  6'd0,  4'd2,  E_DECODE});
    seq.push_back('{1'b1, OP_BEQ,  6'd0,  4'd9,  E_BEQ});
    seq.push_back('{1'b1, OP_J,    6'd0,  4'd1,  E_FETCH_R});
    seq.push_back('{1'b1, OP_J,    6'd0,  4'd2,  E_DECODE});
    seq.push_back('{1'b1, OP_J,    6'd0,  4'd10, E_JUMP});
    seq.push_back('{1'b1, OP_R,    FN_JR, 4'd1,  E_FETCH_R});
    seq.push_back('{1'b1, OP_R,    FN_JR, 4'd2,  E_DECODE});
    seq.push_back('{1'b1, OP_R,    FN_JR, 4'd12, E_JR});
    seq.push_back('{1'b1, OP_R,    FN_JR, 4'd1,  E_FETCH_R});
    for (int i = 0; i < seq.size(); i++) begin
      mem_ready = seq[i].rdy; instr_op = seq[i].op; funct = seq[i].fn;
      #1;
      checks++;
      if (state !== seq[i].st) begin errors++; $display("FAIL b2b_state[%0d]: got %0d expected %0d", i, state, seq[i].st); end
      checks++;
      if (outs !== seq[i].out) begin errors++; $display("FAIL b2b_ctl[%0d]: got %h expected %h", i, outs, seq[i].out); end
      if (i < seq.size() - 1) tick();
    end
    exp_cnt = exp_cnt + 4'd5;
    checks++;
    if (instr_cnt !== exp_cnt) begin errors++; $display("FAIL b2b_cnt: got %0d expected %0d", instr_cnt, exp_cnt); end
  endtask

  task automatic test_timeout_ready;
    step_t seq[$];
    for (int i = 0; i < 4; i++) seq.push_back('{1'b0, OP_J, 6'd0, 4'd1, E_FETCH_NR});
    seq.push_back('{1'b1, OP_J, 6'd0, 4'd1,  E_FETCH_R});
    seq.push_back('{1'b1, OP_J, 6'd0, 4'd2,  E_DECODE});
    seq.push_back('{1'b1, OP_J, 6'd0, 4'd10, E_JUMP});
    seq.push_back('{1'b1, OP_J, 6'd0, 4'd1,  E_FETCH_R});
    for (int i = 0; i < seq.size(); i++) begin
      mem_ready = seq[i].rdy; instr_op = seq[i].op; funct = seq[i].fn;
      #1;
      checks++;
      if (state !== seq[i].st) begin errors++; $display("FAIL to_ready_state[%0d]: got %0d expected %0d", i, state, seq[i].st); end
      checks++;
      if (outs !== seq[i].out) begin errors++; $display("FAIL to_ready_ctl[%0d]: got %h expected %h", i, outs, seq[i].out); end
      if (i < seq.size() - 1) tick();
    end
    exp_cnt = exp_cnt + 4'd1;
    checks++;
    if (instr_cnt !== exp_cnt) begin errors++; $display("FAIL to_ready_cnt: got %0d expected %0d", instr_cnt, exp_cnt); end
  endtask

  task automatic test_cnt_wrap;
    int n;
    n = 16 - int'(exp_cnt);
    mem_ready = 1'b1; instr_op = OP_J; funct = '0;
    for (int k = 0; k < n; k++) begin
      if (k == n - 1) begin
        checks++;
        if (instr_cnt !== 4'hF) begin errors++; $display("FAIL wrap_pre: got %0d expected 15", instr_cnt); end
      end
      tick(); tick(); tick();
      #1;
      checks++;
      if (state !== 4'd1) begin errors++; $display("FAIL wrap_state[%0d]: got %0d expected 1", k, state); end
    end
    exp_cnt = exp_cnt + 4'(n);
    checks++;
    if (instr_cnt !== 4'd0) begin errors++; $display("FAIL wrap_cnt: got %0d expected 0", instr_cnt); end
  endtask

  task automatic test_reset_mid_memrd;
    step_t seq[$];
    seq.push_back('{1'b1, OP_J,  6'd0, 4'd1,  E_FETCH_R});
    seq.push_back('{1'b1, OP_J,  6'd0, 4'd2,  E_DECODE});
    seq.push_back('{1'b1, OP_J,  6'd0, 4'd10, E_JUMP});
    seq.push_back('{1'b1, OP_LW, 6'd0, 4'd1,  E_FETCH_R});
    seq.push_back('{1'b1, OP_LW, 6'd0, 4'd2,  E_DECODE});
    seq.push_back('{1'b1, OP_LW, 6'd0, 4'd3,  E_MEMADR});
    seq.push_back('{1'b0, OP_LW, 6'd0, 4'd4,  E_MEMRD});
    for (int i = 0; i < seq.size(); i++) begin
      mem_ready = seq[i].rdy; instr_op = seq[i].op; funct = seq[i].fn;
      #1;
      checks++;
      if (state !== seq[i].st) begin errors++; $display("FAIL mrst_state[%0d]: got %0d expected %0d", i, state, seq[i].st); end
      checks++;
      if (outs !== seq[i].out) begin errors++; $display("FAIL mrst_ctl[%0d]: got %h expected %h", i, outs, seq[i].out); end
      if (i < seq.size() - 1) tick();
    end
    checks++;
    if (instr_cnt !== exp_cnt + 4'd1) begin errors++; $display("FAIL mrst_cnt_before: got %0d expected %0d", instr_cnt, exp_cnt + 4'd1); end
    rst_n = 1'b0;
    #1;
    exp_cnt = '0;
    checks++;
    if (state !== 4'd0) begin errors++; $display("FAIL mrst_async_state: got %0d expected 0", state); end
    checks++;
    if (outs !== E_ZERO) begin errors++; $display("FAIL mrst_async_outs: got %h expected %h", outs, E_ZERO); end
    checks++;
    if (instr_cnt !== 4'd0) begin errors++; $display("FAIL mrst_async_cnt: got %0d expected 0", instr_cnt); end
    @(posedge clk);
    #5 rst_n = 1'b1;
    mem_ready = 1'b1;
    #1;
    checks++;
    if (state !== 4'd0) begin errors++; $display("FAIL mrst_release_state: got %0d expected 0", state); end
    tick();
    #1;
    checks++;
    if (state !== 4'd1) begin errors++; $display("FAIL mrst_fetch_state: got %0d expected 1", state); end
  endtask

  task automatic test_illegal;
    step_t seq[$];
    seq.push_back('{1'b1, OP_J,   6'd0, 4'd1,  E_FETCH_R});
    seq.push_back('{1'b1, OP_J,   6'd0, 4'd2,  E_DECODE});
    seq.push_back('{1'b1, OP_J,   6'd0, 4'd10, E_JUMP});
    seq.push_back('{1'b1, OP_BAD, 6'd0, 4'd1,  E_FETCH_R});
    seq.push_back('{1'b1, OP_BAD, 6'd0, 4'd2,  E_DECODE});
    seq.push_back('{1'b1, OP_BAD, 6'd0, 4'd15, E_ERR});
    seq.push_back('{1'b0, OP_J,   6'd0, 4'd15, E_ERR});
    seq.push_back('{1'b1, OP_J,   6'd0, 4'd15, E_ERR});
    for (int i = 0; i < seq.size(); i++) begin
      mem_ready = seq[i].rdy; instr_op = seq[i].op; funct = seq[i].fn;
      #1;
      checks++;
      if (state !== seq[i].st) begin errors++; $display("FAIL ill_state[%0d]: got %0d expected %0d", i, state, seq[i].st); end
      checks++;
      if (outs !== seq[i].out) begin errors++; $display("FAIL ill_ctl[%0d]: got %h expected %h", i, outs, seq[i].out); end
      if (i < seq.size() - 1) tick();
    end
    exp_cnt = exp_cnt + 4'd1;
    checks++;
    if (instr_cnt !== exp_cnt) begin errors++; $display("FAIL ill_cnt: got %0d expected %0d", instr_cnt, exp_cnt); end
  endtask

  task automatic test_timeout_trap;
    step_t seq[$];
    rst_n = 1'b0;
    @(posedge clk);
    #5 rst_n = 1'b1;
    mem_ready = 1'b0;
    exp_cnt = '0;
    tick();
    for (int i = 0; i < 5; i++) seq.push_back('{1'b0, OP_J, 6'd0, 4'd1, E_FETCH_NR});
    seq.push_back('{1'b0, OP_J, 6'd0, 4'd15, E_ERR});
    seq.push_back('{1'b1, OP_J, 6'd0, 4'd15, E_ERR});
    seq.push_back('{1'b1, OP_J, 6'd0, 4'd15, E_ERR});
    for (int i = 0; i < seq.size(); i++) begin
      mem_ready = seq[i].rdy; instr_op = seq[i].op; funct = seq[i].fn;
      #1;
      checks++;
      if (state !== seq[i].st) begin errors++; $display("FAIL trap_state[%0d]: got %0d expected %0d", i, state, seq[i].st); end
      checks++;
      if (outs !== seq[i].out) begin errors++; $display("FAIL trap_ctl[%0d]: got %h expected %h", i, outs, seq[i].out); end
      if (i < seq.size() - 1) tick();
    end
    checks++;
    if (instr_cnt !== exp_cnt) begin errors++; $display("FAIL trap_cnt: got %0d expected %0d", instr_cnt, exp_cnt); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_lw_wait();
    test_branch_jal();
    test_back_to_back();
    test_timeout_ready();
    test_cnt_wrap();
    test_reset_mid_memrd();
    test_illegal();
    test_timeout_trap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Control FSM for the multi-cycle generation of the team's MIPS-subset CPU: one shared memory port, a single ALU reused across cycles, and an instruction register (IR).
- Replaces the single-cycle combinational decoder.
- Adds memory wait states with a ready handshake, a bus timeout, illegal-opcode trapping and a retired-instruction counter.
- Outputs drive the multi-cycle datapath muxes and enables.

Parameters:
TO_W, 8, width of memory-wait timeout counter
TIMEOUT, 200, wait cycles without mem_ready_i before trapping (1..2^TO_W-1)
CNT_W, 32, width of retired-instruction counter

Ports:
clk_i  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
instr_op_i  in  6  IR[31:26]
funct_i  in  6  IR[5:0]
mem_ready_i  in  1  memory completes the current read/write this cycle
PCWrite_o  out  1  unconditional PC load
PCWriteCond_o  out  1  PC load if branch condition holds
BranchType_o  out  1  0 = beq (Zero), 1 = bne (~Zero)
IorD_o  out  1  memory address: 0 = PC, 1 = ALUOut
MemRead_o  out  1  memory read request
MemWrite_o  out  1  memory write request
IRWrite_o  out  1  IR load
RegDst_o  out  2  0 = rt, 1 = rd, 2 = $31
MemtoReg_o  out  2  0 = ALUOut, 1 = MDR, 2 = PC
RegWrite_o  out  1  register file write
ALUSrcA_o  out  1  0 = PC, 1 = rs
ALUSrcB_o  out  2  0 = rt, 1 = const 4, 2 = sign-ext imm, 3 = sign-ext imm<<2
ALUOp_o  out  3  0 = add, 1 = sub, 2 = use funct
PCSource_o  out  2  0 = ALU result, 1 = ALUOut, 2 = jump target, 3 = rs
err_o  out  1  controller trapped
state_o  out  4  current state encoding
instr_cnt_o  out  CNT_W  retired instructions

Behaviour:
- Encodings:
  - Opcodes: R 000000, addi 001000, lw 100011, sw 101011, beq 000100, bne 000101, j 000010, jal 000011.
  - jr = R with funct 001000.
- States: START 0, FETCH 1, DECODE 2, MEMADR 3, MEMRD 4, MEMWB 5, MEMWR 6, EXEC 7, RWB 8, BRANCH 9, JUMP 10, JAL 11, JR 12, ADDIEX 13, ADDIWB 14, ERR 15.
- Reset (async):
  - State forced to START; timeout counter and instr_cnt_o cleared.
  - Every output is 0 in START; START -> FETCH unconditionally next edge.
- Output style: outputs are decoded from the registered state (Moore), except signals marked "on ready", which are additionally ANDed with mem_ready_i. Unlisted outputs are 0.
- FETCH:
  - Drives MemRead=1, IorD=0.
  - On ready: IRWrite=1, PCWrite=1, SrcA=0, SrcB=1, ALUOp=0, PCSource=0.
  - Stays in FETCH until ready, then -> DECODE.
- DECODE:
  - Drives SrcA=0, SrcB=3, ALUOp=0 (branch target into ALUOut).
  - Next state by opcode: lw/sw -> MEMADR, R -> EXEC (jr -> JR), addi -> ADDIEX, beq/bne -> BRANCH, j -> JUMP, jal -> JAL, anything else -> ERR.
- MEMADR: SrcA=1, SrcB=2, ALUOp=0; lw -> MEMRD, sw -> MEMWR.
- MEMRD: MemRead=1, IorD=1; waits for ready, then -> MEMWB.
- MEMWB: RegWrite=1, RegDst=0, MemtoReg=1; -> FETCH.
- MEMWR: MemWrite=1, IorD=1; waits for ready, then -> FETCH.
- EXEC: SrcA=1, SrcB=0, ALUOp=2; -> RWB.
- RWB: RegWrite=1, RegDst=1, MemtoReg=0; -> FETCH.
- ADDIEX: SrcA=1, SrcB=2, ALUOp=0; -> ADDIWB.
- ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0; -> FETCH.
- BRANCH: SrcA=1, SrcB=0, ALUOp=1, PCWriteCond=1, PCSource=1, BranchType=opcode[0]; -> FETCH.
- JUMP: PCWrite=1, PCSource=2; -> FETCH.
- JAL: PCWrite=1, PCSource=2, RegWrite=1, RegDst=2, MemtoReg=2; -> FETCH. PC at this point already holds PC+4.
- JR: PCWrite=1, PCSource=3; -> FETCH.
- Timeout:
  - Counter increments each cycle spent in FETCH, MEMRD or MEMWR with mem_ready_i=0.
  - Clears on leaving the state or on ready.
  - When it would reach TIMEOUT (the TIMEOUT-th consecutive non-ready cycle), next state is ERR.
  - Ready arriving in that same cycle wins: normal transition, no trap.
- ERR: err_o=1, all other outputs 0; sticky until reset.
- instr_cnt_o:
  - Increments by 1 on the edge leaving MEMWB, MEMWR-on-ready, RWB, ADDIWB, BRANCH, JUMP, JAL or JR.
  - Wraps modulo 2^CNT_W; never increments in ERR.
- Latency (zero wait states): R/addi 4 cycles, lw 5, sw 4, branch/jumps 3.

Test Plan:
- rst_n low mid-MEMRD → async: state_o=0 and all outputs 0 immediately; instr_cnt_o=0; after release, FETCH on the second edge.
- add (op 0, funct 100000), mem_ready_i tied 1 → state sequence 1,2,7,8,1; RegWrite=1 and RegDst=1 only in RWB; instr_cnt_o +1.
- lw with mem_ready_i low for 3 cycles in MEMRD → MEMRD held 4 cycles, MemRead=1 and IorD=1 throughout, then MEMWB with MemtoReg=1; total 8 cycles.
- bne (000101) → BRANCH with BranchType=1, PCWriteCond=1, PCSource=1; jal → RegDst=2, MemtoReg=2, PCSource=2.
- TIMEOUT=5, mem_ready_i held 0 in FETCH → ERR entered after 5 cycles, err_o=1 sticky; ready on 5th cycle → DECODE, no trap.
- Opcode 111111 → DECODE→ERR, err_o=1, instr_cnt_o unchanged; CNT_W=4 with 16 retired instructions → wraps to 0.
